// File: rtl/i2c_sub_reg_ctrl_if.sv
// Byte-event and register-bus signals between the I2C subordinate byte layer,
// the register-access controller and the on-chip register bus.
// The master modport is the controller's view; the slave modport is the view
// of everything around it (byte engine plus register target).
interface i2c_sub_reg_ctrl_if #(
    parameter int AW = 8
);
    logic          ev_start;
    logic          ev_stop;
    logic          ev_addr;
    logic          ev_rw;
    logic          ev_rx;
    logic [7:0]    rx_byte;
    logic          ev_mack;
    logic          mnack;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          hold_clock_low;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_wr;
    logic          reg_rd;
    logic [7:0]    reg_rdata;
    logic          reg_rvalid;
    logic          err_timeout;

    modport master (
        input  ev_start, ev_stop, ev_addr, ev_rw, ev_rx, rx_byte,
        input  ev_mack, mnack, reg_rdata, reg_rvalid,
        output tx_byte, tx_valid, hold_clock_low,
        output reg_addr, reg_wdata, reg_wr, reg_rd, err_timeout
    );

    modport slave (
        output ev_start, ev_stop, ev_addr, ev_rw, ev_rx, rx_byte,
        output ev_mack, mnack, reg_rdata, reg_rvalid,
        input  tx_byte, tx_valid, hold_clock_low,
        input  reg_addr, reg_wdata, reg_wr, reg_rd, err_timeout
    );
endinterface

// File: rtl/i2c_sub_reg_ctrl.sv
// Register-access controller behind the I2C subordinate byte engine.
// Keeps the register pointer, turns received bytes into register writes and
// fetches read bytes, stretching SCL while a read return is outstanding.
// A read that times out returns 0xFF and leaves its late return to be dropped.
module i2c_sub_reg_ctrl #(
    parameter int AW          = 8,
    parameter int STRETCH_MAX = 255
) (
    input logic             clk,
    input logic             rst,
    i2c_sub_reg_ctrl_if.master bus
);
    localparam int CW = $clog2(STRETCH_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        W_PTR,
        W_DATA,
        R_FETCH,
        R_SEND
    } state_t;

    state_t        state_q;
    logic [AW-1:0] ptr_q;
    logic          pend_drop_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    tx_byte_q;
    logic          tx_valid_q;
    logic          hold_q;
    logic [AW-1:0] reg_addr_q;
    logic [7:0]    reg_wdata_q;
    logic          reg_wr_q;
    logic          reg_rd_q;
    logic          err_q;

    logic [AW-1:0] ptr_inc_d;
    logic          fresh_rvalid_d;
    logic          timeout_d;
    logic          do_write_d;
    logic          do_fetch_d;

    assign ptr_inc_d      = ptr_q + AW'(1);
    // A return that arrives while a drop is pending belongs to an aborted read.
    assign fresh_rvalid_d = bus.reg_rvalid & ~pend_drop_q;
    assign timeout_d      = (cnt_q == CW'(STRETCH_MAX - 1));

    // A byte received in the data phase is written even when STOP lands on the
    // same cycle; a START or address match on that cycle takes precedence.
    assign do_write_d = bus.ev_rx && (state_q == W_DATA) &&
                        (bus.ev_stop || (!bus.ev_start && !bus.ev_addr));

    // Read fetch is launched by a read address match or a master ACK.
    assign do_fetch_d = !bus.ev_stop && !bus.ev_start &&
                        ((bus.ev_addr && bus.ev_rw && (state_q == IDLE)) ||
                         (!bus.ev_addr && (state_q == R_SEND) && bus.ev_mack && !bus.mnack));

    // Controller FSM with registered bus-side and byte-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pend_drop_q <= 1'b0;
            cnt_q       <= '0;
            tx_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            hold_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            reg_wr_q <= 1'b0;
            reg_rd_q <= 1'b0;

            if (bus.reg_rvalid && pend_drop_q) begin
                pend_drop_q <= 1'b0;
            end

            if (bus.ev_stop || bus.ev_start) begin
                state_q    <= IDLE;
                hold_q     <= 1'b0;
                tx_valid_q <= 1'b0;
                if (bus.ev_start) begin
                    err_q <= 1'b0;
                end
                // Aborting a fetch leaves its return in flight unless it lands now.
                if (state_q == R_FETCH) begin
                    pend_drop_q <= pend_drop_q | ~bus.reg_rvalid;
                end
            end else if (bus.ev_addr) begin
                if ((state_q == IDLE) && !bus.ev_rw) begin
                    state_q <= W_PTR;
                end
            end else begin
                unique case (state_q)
                    W_PTR: begin
                        if (bus.ev_rx) begin
                            ptr_q   <= AW'(bus.rx_byte);
                            state_q <= W_DATA;
                        end
                    end
                    R_FETCH: begin
                        if (fresh_rvalid_d) begin
                            tx_byte_q  <= bus.reg_rdata;
                            tx_valid_q <= 1'b1;
                            hold_q     <= 1'b0;
                            ptr_q      <= ptr_inc_d;
                            state_q    <= R_SEND;
                        end else if (timeout_d) begin
                            tx_byte_q   <= 8'hFF;
                            tx_valid_q  <= 1'b1;
                            hold_q      <= 1'b0;
                            err_q       <= 1'b1;
                            ptr_q       <= ptr_inc_d;
                            pend_drop_q <= 1'b1;
                            state_q     <= R_SEND;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    R_SEND: begin
                        if (bus.ev_mack && bus.mnack) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end

            if (do_write_d) begin
                reg_wr_q    <= 1'b1;
                reg_addr_q  <= ptr_q;
                reg_wdata_q <= bus.rx_byte;
                ptr_q       <= ptr_inc_d;
            end

            if (do_fetch_d) begin
                reg_rd_q   <= 1'b1;
                reg_addr_q <= ptr_q;
                hold_q     <= 1'b1;
                tx_valid_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= R_FETCH;
            end
        end
    end

    assign bus.tx_byte        = tx_byte_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.hold_clock_low = hold_q;
    assign bus.reg_addr       = reg_addr_q;
    assign bus.reg_wdata      = reg_wdata_q;
    assign bus.reg_wr         = reg_wr_q;
    assign bus.reg_rd         = reg_rd_q;
    assign bus.err_timeout    = err_q;
endmodule

// File: tb/tb_i2c_sub_reg_ctrl.sv
// Bench for i2c_sub_reg_ctrl: the bench plays byte engine and register target,
// and keeps a plain array/pointer model of the register space to predict every
// write strobe and every returned read byte.
module tb_i2c_sub_reg_ctrl;
    localparam int AW   = 8;
    localparam int SMAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_sub_reg_ctrl_if #(.AW(AW)) bif ();

    i2c_sub_reg_ctrl #(.AW(AW), .STRETCH_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int         checks  = 0;
    int         errors  = 0;
    int         nwr     = 0;
    int         nrd     = 0;
    int         exp_nwr = 0;
    int         exp_nrd = 0;
    logic [7:0] tgt_mem   [256];
    logic [7:0] model_mem [256];
    logic [7:0] exp_ptr;
    logic [7:0] rd_addr;
    logic [7:0] held;
    logic [7:0] p;
    int         n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs observed 1 time unit after the edge, pulses cleared,
    // the register target absorbs any write strobe.
    task automatic step();
        @(posedge clk);
        #1;
        bif.ev_start   = 1'b0;
        bif.ev_stop    = 1'b0;
        bif.ev_addr    = 1'b0;
        bif.ev_rx      = 1'b0;
        bif.ev_mack    = 1'b0;
        bif.reg_rvalid = 1'b0;
        if (bif.reg_wr === 1'b1) begin
            nwr++;
            tgt_mem[bif.reg_addr] = bif.reg_wdata;
        end
        if (bif.reg_rd === 1'b1) nrd++;
        chk("rd_wr_exclusive", 32'(bif.reg_rd & bif.reg_wr), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tx_byte"},  32'(bif.tx_byte), 32'd0);
        chk({tag, "_tx_valid"}, 32'(bif.tx_valid), 32'd0);
        chk({tag, "_hold"},     32'(bif.hold_clock_low), 32'd0);
        chk({tag, "_reg_addr"}, 32'(bif.reg_addr), 32'd0);
        chk({tag, "_wdata"},    32'(bif.reg_wdata), 32'd0);
        chk({tag, "_reg_wr"},   32'(bif.reg_wr), 32'd0);
        chk({tag, "_reg_rd"},   32'(bif.reg_rd), 32'd0);
        chk({tag, "_err"},      32'(bif.err_timeout), 32'd0);
    endtask

    task automatic wr_open(input logic [7:0] ptr);
        bif.ev_start = 1'b1; step();
        bif.ev_addr = 1'b1; bif.ev_rw = 1'b0; step();
        bif.ev_rx = 1'b1; bif.rx_byte = ptr; step();
        chk("wptr_no_write", 32'(bif.reg_wr), 32'd0);
        exp_ptr = ptr;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bif.ev_rx = 1'b1; bif.rx_byte = b; step();
        chk("wr_strobe", 32'(bif.reg_wr), 32'd1);
        chk("wr_addr", 32'(bif.reg_addr), 32'(exp_ptr));
        chk("wr_data", 32'(bif.reg_wdata), 32'(b));
        model_mem[exp_ptr] = b;
        exp_ptr = exp_ptr + 8'd1;
        exp_nwr++;
    endtask

    task automatic frame_stop();
        bif.ev_stop = 1'b1; step();
        chk("stop_hold", 32'(bif.hold_clock_low), 32'd0);
        chk("stop_txv", 32'(bif.tx_valid), 32'd0);
    endtask

    task automatic chk_fetch(input string tag);
        chk({tag, "_rd"}, 32'(bif.reg_rd), 32'd1);
        chk({tag, "_addr"}, 32'(bif.reg_addr), 32'(exp_ptr));
        chk({tag, "_hold"}, 32'(bif.hold_clock_low), 32'd1);
        chk({tag, "_txv"}, 32'(bif.tx_valid), 32'd0);
        rd_addr = bif.reg_addr;
        exp_nrd++;
    endtask

    task automatic rd_start();
        bif.ev_start = 1'b1; step();
        bif.ev_addr = 1'b1; bif.ev_rw = 1'b1; step();
        chk_fetch("rd_start");
    endtask

    task automatic rd_finish(input int lat);
        for (int k = 0; k < lat; k++) begin
            step();
            chk("stretch_hold", 32'(bif.hold_clock_low), 32'd1);
            chk("stretch_no_rd", 32'(bif.reg_rd), 32'd0);
        end
        bif.reg_rdata = tgt_mem[rd_addr]; bif.reg_rvalid = 1'b1; step();
        chk("rd_tx_byte", 32'(bif.tx_byte), 32'(model_mem[exp_ptr]));
        chk("rd_tx_valid", 32'(bif.tx_valid), 32'd1);
        chk("rd_hold_off", 32'(bif.hold_clock_low), 32'd0);
        exp_ptr = exp_ptr + 8'd1;
    endtask

    task automatic rd_ack();
        bif.ev_mack = 1'b1; bif.mnack = 1'b0; step();
        chk_fetch("ack_prefetch");
    endtask

    task automatic rd_nack();
        bif.ev_mack = 1'b1; bif.mnack = 1'b1; step();
        chk("nack_txv", 32'(bif.tx_valid), 32'd0);
        chk("nack_hold", 32'(bif.hold_clock_low), 32'd0);
    endtask

    initial begin
        bif.ev_start = 1'b0; bif.ev_stop = 1'b0; bif.ev_addr = 1'b0; bif.ev_rw = 1'b0;
        bif.ev_rx = 1'b0; bif.rx_byte = 8'h00; bif.ev_mack = 1'b0; bif.mnack = 1'b0;
        bif.reg_rdata = 8'h00; bif.reg_rvalid = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tgt_mem[i]   = 8'($urandom);
            model_mem[i] = tgt_mem[i];
        end
        exp_ptr = 8'h00;

        // Reset state
        step(); step();
        chk_zero("reset");
        rst = 1'b1;
        step();

        // Write burst 0x10: A5, 5A
        wr_open(8'h10);
        wr_byte(8'hA5);
        wr_byte(8'h5A);
        frame_stop();

        // Read from 0x11 with 3-cycle latency, ACK, then NACK
        wr_open(8'h11);
        frame_stop();
        rd_start();
        rd_finish(3);
        chk("spec_read_5a", 32'(bif.tx_byte), 32'h5A);
        held = bif.tx_byte;
        step(); step();
        chk("rsend_stable_byte", 32'(bif.tx_byte), 32'(held));
        chk("rsend_stable_valid", 32'(bif.tx_valid), 32'd1);
        rd_ack();
        chk("ack_addr_12", 32'(bif.reg_addr), 32'h12);
        rd_finish(1);
        rd_nack();
        frame_stop();

        // Pointer wrap 0xFF -> 0x00
        wr_open(8'hFF);
        wr_byte(8'($urandom));
        wr_byte(8'($urandom));
        frame_stop();

        // Timeout: no return for SMAX cycles
        wr_open(8'h40);
        frame_stop();
        rd_start();
        for (int k = 0; k < SMAX - 1; k++) begin
            step();
            chk("to_hold", 32'(bif.hold_clock_low), 32'd1);
        end
        step();
        chk("to_byte", 32'(bif.tx_byte), 32'hFF);
        chk("to_valid", 32'(bif.tx_valid), 32'd1);
        chk("to_hold_off", 32'(bif.hold_clock_low), 32'd0);
        chk("to_err", 32'(bif.err_timeout), 32'd1);
        exp_ptr = exp_ptr + 8'd1;
        bif.reg_rdata = 8'h77; bif.reg_rvalid = 1'b1; step();
        chk("late_rvalid_dropped", 32'(bif.tx_byte), 32'hFF);
        rd_ack();
        rd_finish(2);
        chk("err_sticky", 32'(bif.err_timeout), 32'd1);
        rd_nack();
        bif.ev_start = 1'b1; step();
        chk("start_clears_err", 32'(bif.err_timeout), 32'd0);
        frame_stop();

        // Abort one cycle after reg_rd; stale return lands in IDLE
        tgt_mem[8'h20] = 8'h33; model_mem[8'h20] = 8'h33;
        tgt_mem[8'h21] = 8'h3C; model_mem[8'h21] = 8'h3C;
        wr_open(8'h20);
        frame_stop();
        rd_start();
        step();
        bif.ev_stop = 1'b1; step();
        chk("abort_hold", 32'(bif.hold_clock_low), 32'd0);
        chk("abort_txv", 32'(bif.tx_valid), 32'd0);
        bif.reg_rdata = 8'h77; bif.reg_rvalid = 1'b1; step();
        chk("stale_idle_txv", 32'(bif.tx_valid), 32'd0);
        rd_start();
        rd_finish(2);
        chk("fresh_33", 32'(bif.tx_byte), 32'h33);
        rd_nack();
        frame_stop();

        // Abort again; stale return lands inside the next fetch
        rd_start();
        step();
        bif.ev_stop = 1'b1; step();
        rd_start();
        bif.reg_rdata = 8'h77; bif.reg_rvalid = 1'b1; step();
        chk("stale_fetch_hold", 32'(bif.hold_clock_low), 32'd1);
        chk("stale_fetch_txv", 32'(bif.tx_valid), 32'd0);
        rd_finish(1);
        rd_nack();
        frame_stop();

        // Randomized transactions against the model
        for (int it = 0; it < 8; it++) begin
            p = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                wr_open(p);
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) wr_byte(8'($urandom));
                frame_stop();
            end else begin
                wr_open(p);
                frame_stop();
                rd_start();
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) begin
                    rd_finish(int'($urandom_range(0, 6)));
                    if (k < n - 1) rd_ack();
                end
                rd_nack();
                frame_stop();
            end
        end

        chk("write_strobe_count", 32'(nwr), 32'(exp_nwr));
        chk("read_strobe_count", 32'(nrd), 32'(exp_nrd));

        // Asynchronous reset mid-fetch
        rd_start();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        rst = 1'b1;
        exp_ptr = 8'h00;
        step();
        rd_start();
        rd_finish(1);
        rd_nack();
        frame_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
